ft245_tx: RTL

FPGA-side transmit path of the FT232H asynchronous FT245 FIFO interface, the counterpart of the host-to-FPGA byte path the controller already reads commands from. It buffers bytes from internal producers (MCP3008 results, AD9826 pixel data, status replies) and writes them to the FT232H by strobing `ft_wr_n` while honouring `ft_txe_n`. It can also request send-immediate through `ft_siwu_n`. It sits beside the FT245 reader under the controller top; the top owns the shared tristate `ft_bus` and the reader/transmitter arbitration.

---
 rtl/ft245_pkg.sv | 24 ++
 rtl/ft245_tx_sync_fifo.sv | 44 ++++
 rtl/ft245_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ft245_pkg.sv
// Shared FT245 definitions: FSM state encoding and default write-timing constants.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SIWU   = 3'd4
  } ft_state_e;

  localparam int FT_FIFO_AW   = 4;
  localparam int FT_SETUP_CYC = 2;
  localparam int FT_WR_CYC    = 3;
  localparam int FT_HOLD_CYC  = 1;
  localparam int FT_SIWU_CYC  = 2;
  localparam int FT_CNT_W     = 8;

  // Terminal value of a phase counter that runs for n clocks.
  function automatic logic [FT_CNT_W-1:0] last_cnt(input int n);
    return FT_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/ft245_tx_sync_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; level is the pointer difference.
module sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_level   = r_wptr - r_rptr;
  assign o_full    = o_level[AW];
  assign o_empty   = (r_wptr == r_rptr);
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ft245_tx.sv
// FT245 async-FIFO transmit path: buffers producer bytes and strobes them into
// the FT232H, with optional send-immediate (SIWU) once the queue drains.
module ft245_tx
  import ft245_pkg::*;
#(
  parameter int FIFO_AW   = FT_FIFO_AW,
  parameter int SETUP_CYC = FT_SETUP_CYC,
  parameter int WR_CYC    = FT_WR_CYC,
  parameter int HOLD_CYC  = FT_HOLD_CYC,
  parameter int SIWU_CYC  = FT_SIWU_CYC
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             flush,
  input  logic             rx_busy,
  input  logic             ft_txe_n,
  output logic [7:0]       ft_data_out,
  output logic             ft_data_oe,
  output logic             ft_wr_n,
  output logic             ft_siwu_n,
  output logic [FIFO_AW:0] tx_level,
  output logic             tx_idle
);

  ft_state_e             r_state, w_state_nx;
  logic [FT_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [1:0]            r_txe_sync;
  logic                  r_wr_n, w_wr_n_nx;
  logic                  r_siwu_n, w_siwu_n_nx;
  logic                  r_oe, w_oe_nx;
  logic [7:0]            r_data, w_data_nx;
  logic                  r_flush_pend, w_flush_nx;
  logic                  w_txe_s;
  logic                  w_push, w_pop;
  logic                  w_full, w_empty;
  logic [7:0]            w_head;

  assign w_txe_s     = r_txe_sync[1];
  assign w_push      = tx_valid & ~w_full;
  assign tx_ready    = ~w_full;
  assign ft_data_out = r_data;
  assign ft_data_oe  = r_oe;
  assign ft_wr_n     = r_wr_n;
  assign ft_siwu_n   = r_siwu_n;
  assign tx_idle     = (r_state == ST_IDLE) & ~r_oe;

  sync_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (tx_level)
  );

  // ft_txe_n is asynchronous to clk_in; synchronizer idles at "no space".
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_txe_sync <= 2'b11;
    else        r_txe_sync <= {r_txe_sync[0], ft_txe_n};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wr_n       <= 1'b1;
      r_siwu_n     <= 1'b1;
      r_oe         <= 1'b0;
      r_data       <= 8'h00;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_wr_n       <= w_wr_n_nx;
      r_siwu_n     <= w_siwu_n_nx;
      r_oe         <= w_oe_nx;
      r_data       <= w_data_nx;
      r_flush_pend <= w_flush_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_wr_n_nx   = r_wr_n;
    w_siwu_n_nx = r_siwu_n;
    w_oe_nx     = r_oe;
    w_data_nx   = r_data;
    w_flush_nx  = r_flush_pend | flush;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        // A queued byte wins over send-immediate; the live flush lets SIWU start next edge.
        if (!w_empty && !w_txe_s && !rx_busy) begin
          w_state_nx = ST_SETUP;
          w_data_nx  = w_head;
          w_oe_nx    = 1'b1;
        end else if (w_empty && (r_flush_pend || flush)) begin
          w_state_nx  = ST_SIWU;
          w_siwu_n_nx = 1'b0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == last_cnt(SETUP_CYC)) begin
          w_state_nx = ST_STROBE;
          w_cnt_nx   = '0;
          w_wr_n_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == last_cnt(WR_CYC)) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = '0;
          w_wr_n_nx  = 1'b1;
          w_pop      = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == last_cnt(HOLD_CYC)) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_oe_nx    = 1'b0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_SIWU: begin
        // Flushes arriving here are absorbed into the pulse already in progress.
        w_flush_nx = r_flush_pend;
        if (r_cnt == last_cnt(SIWU_CYC)) begin
          w_state_nx  = ST_IDLE;
          w_cnt_nx    = '0;
          w_siwu_n_nx = 1'b1;
          w_flush_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

endmodule
